serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first, with a rippling borrow flip-flop.
- It is the inverse arithmetic counterpart of the team's adder cells and is used where a full parallel subtractor costs too much area.
- Operands are captured with a start/busy/done handshake.
- The result and final borrow are held stable until the next operation completes.

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;

    // One full-subtractor cell applied to the current LSBs.
    always_comb begin
        d_bit   = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sr_next = {d_bit, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    // diff/bout are only published here, so they never show a partial shift.
                    if (cnt == LAST) begin
                        diff  <= sr_next;
                        bout  <= br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    // Launches one 8-bit operation and waits for done; lat counts negedges after the start edge.
    task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                       output int lat, output logic [7:0] d, output logic bo);
        @(negedge clk);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~xa; b = ~xb; bin = ~xbin;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = diff;
        bo = bout;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, bout} !== 11'b0)
            $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b expected all 0", busy, done, diff, bout);
        else passes++;
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'b0)
            $display("FAIL reset4 got busy=%b done=%b diff=%h bout=%b expected all 0", busy4, done4, diff4, bout4);
        else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int bad = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h00) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) $display("FAIL basic_busy_window got %0d bad cycles expected 0", bad);
        else passes++;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_done got done=%b busy=%b expected done=1 busy=0", done, busy);
        else passes++;
        checks++;
        if (diff !== 8'h1E || bout !== 1'b0)
            $display("FAIL basic_result got %h/%b expected 1e/0", diff, bout);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || diff !== 8'h1E)
            $display("FAIL basic_done_pulse got done=%b diff=%h expected done=0 diff=1e", done, diff);
        else passes++;
    endtask

    task automatic test_vectors;
        logic [7:0] va [3] = '{8'h00, 8'h10, 8'hFF};
        logic [7:0] vb [3] = '{8'h01, 8'h10, 8'h00};
        logic       vi [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ed [3] = '{8'hFF, 8'hFF, 8'hFE};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        logic [7:0] d;
        logic bo;
        for (int k = 0; k < 3; k++) begin
            op8(va[k], vb[k], vi[k], lat, d, bo);
            checks++;
            if (lat != 9) $display("FAIL vec%0d_latency got %0d expected 9", k, lat);
            else passes++;
            checks++;
            if (d !== ed[k] || bo !== eb[k])
                $display("FAIL vec%0d_result got %h/%b expected %h/%b", k, d, bo, ed[k], eb[k]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [3] = '{8'h80, 8'h03, 8'hC8};
        logic [7:0] vb [3] = '{8'h01, 8'h07, 8'h64};
        logic       vi [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] ed [3] = '{8'h7F, 8'hFB, 8'h64};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        int done_cyc [3];
        int n;
        @(negedge clk);
        a = va[0]; b = vb[0]; bin = vi[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!busy && n < 30) begin @(negedge clk); n++; end
            if (k < 2) begin
                a = va[k+1]; b = vb[k+1]; bin = vi[k+1];
            end else begin
                start = 1'b0; a = 8'h55; b = 8'hAA; bin = 1'b1;
            end
            n = 0;
            while (!done && n < 30) begin @(negedge clk); n++; end
            done_cyc[k] = cyc;
            checks++;
            if (d_ok(k, ed[k], eb[k]) == 0)
                $display("FAIL b2b%0d_result got %h/%b expected %h/%b", k, diff, bout, ed[k], eb[k]);
            else passes++;
            if (k > 0) begin
                checks++;
                if (done_cyc[k] - done_cyc[k-1] != 10)
                    $display("FAIL b2b%0d_period got %0d expected 10", k, done_cyc[k] - done_cyc[k-1]);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    function automatic int d_ok(input int k, input logic [7:0] e, input logic eb_);
        return (done === 1'b1 && diff === e && bout === eb_) ? 1 : 0;
    endfunction

    task automatic test_ignore_start;
        int n = 0;
        @(negedge clk);
        a = 8'h22; b = 8'h11; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h01; b = 8'hF0; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || diff !== 8'h10 || bout !== 1'b0)
            $display("FAIL ignore_result got done=%b %h/%b expected 1 10/0", done, diff, bout);
        else passes++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL ignore_done_start got busy=%b done=%b expected 0/0", busy, done);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int lat;
        logic [7:0] d;
        logic bo;
        @(negedge clk);
        a = 8'h9C; b = 8'h21; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, diff, bout} !== 11'b0)
            $display("FAIL rstmid_state got busy=%b done=%b diff=%h bout=%b expected all 0", busy, done, diff, bout);
        else passes++;
        repeat (12) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) $display("FAIL rstmid_no_done got %0d pulses expected 0", seen);
        else passes++;
        op8(8'h01, 8'h02, 1'b0, lat, d, bo);
        checks++;
        if (lat != 9 || d !== 8'hFF || bo !== 1'b1)
            $display("FAIL rstmid_recover got lat=%0d %h/%b expected 9 ff/1", lat, d, bo);
        else passes++;
    endtask

    task automatic test_exhaustive4;
        logic [8:0] v;
        logic [4:0] ref_r;
        int n;
        int bad = 0;
        int tmo = 0;
        for (int i = 0; i < 512; i++) begin
            v = i[8:0];
            @(negedge clk);
            a4 = v[8:5]; b4 = v[4:1]; bin4 = v[0]; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 20) begin @(negedge clk); n++; end
            if (!done4) tmo++;
            ref_r = {1'b0, v[8:5]} - {1'b0, v[4:1]} - {4'b0, v[0]};
            if (diff4 !== ref_r[3:0] || bout4 !== ref_r[4]) begin
                bad++;
                if (bad <= 4)
                    $display("FAIL exh4 a=%h b=%h bin=%b got %h/%b expected %h/%b",
                             v[8:5], v[4:1], v[0], diff4, bout4, ref_r[3:0], ref_r[4]);
            end
        end
        checks++;
        if (bad != 0) $display("FAIL exh4_total got %0d wrong expected 0", bad);
        else passes++;
        checks++;
        if (tmo != 0) $display("FAIL exh4_timeout got %0d timeouts expected 0", tmo);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_exhaustive4();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
